// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI master serializer.
package spi_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} spi_state_t;

    localparam int DEF_WORD_SIZE = 8;
    localparam int DEF_CLK_DIV   = 4;
endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: high half then low half per bit, CLK_DIV cycles each, with
// one-cycle strobes for the first high cycle, the last high cycle and the last low cycle.
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall,
    output logic period_end
);
    localparam int CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] DIV_TC = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;
    logic          lo;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= '0;
            lo  <= 1'b0;
        end else if (cnt == DIV_TC) begin
            cnt <= '0;
            lo  <= ~lo;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // fall marks the clk edge on which sclk drops; period_end the edge that ends the bit
    assign sclk       = en & ~lo;
    assign rise       = en & ~lo & (cnt == '0);
    assign fall       = en & ~lo & (cnt == DIV_TC);
    assign period_end = en &  lo & (cnt == DIV_TC);
endmodule

// File: rtl/spi_master_shifter.sv
// SPI mode-0 master: pops words from an upstream buffer and shifts them out MSB first.
// Define SPI_SHIFTER_RX_EN to capture MISO into rx_data with an rx_write push strobe.
module spi_master_shifter
    import spi_pkg::*;
#(
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int CLK_DIV   = DEF_CLK_DIV
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    input  logic [WORD_SIZE-1:0] tx_data,
    output logic                 tx_read,
    output logic                 sclk,
    output logic                 mosi,
    output logic                 cs_n,
    input  logic                 miso,
    output logic [WORD_SIZE-1:0] rx_data,
    output logic                 rx_write,
    output logic                 busy
);
    localparam int BW = $clog2(WORD_SIZE);
    localparam int CW = $clog2(CLK_DIV + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WORD_SIZE - 1);
    localparam logic [CW-1:0] DIV_TC   = CW'(CLK_DIV - 1);

    spi_state_t           state;
    logic [WORD_SIZE-1:0] tx_sr;
    logic [BW-1:0]        bit_cnt;
    logic [CW-1:0]        wait_cnt;
    logic                 draining;
    logic                 sclk_en, rise, fall, period_end, word_end;

    assign sclk_en = (state == SHIFT);

    spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
        .clk       (clk),
        .rst       (rst),
        .en        (sclk_en),
        .sclk      (sclk),
        .rise      (rise),
        .fall      (fall),
        .period_end(period_end)
    );

    assign word_end = fall && (bit_cnt == LAST_BIT) && !draining;
    assign tx_read  = !rst && tx_valid && ((state == IDLE) || word_end);
    assign busy     = (state != IDLE);
    assign mosi     = tx_sr[WORD_SIZE-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cs_n     <= 1'b1;
            tx_sr    <= '0;
            bit_cnt  <= '0;
            wait_cnt <= '0;
            draining <= 1'b0;
        end else begin
            case (state)
                IDLE: if (tx_valid) begin
                    tx_sr <= tx_data;
                    cs_n  <= 1'b0;
                    state <= SETUP;
                end
                SETUP: if (wait_cnt == DIV_TC) begin
                    wait_cnt <= '0;
                    bit_cnt  <= '0;
                    draining <= 1'b0;
                    state    <= SHIFT;
                end else begin
                    wait_cnt <= wait_cnt + CW'(1);
                end
                SHIFT: begin
                    // A reload on the last fall reuses the remaining low half as setup time
                    if (word_end && tx_valid) begin
                        tx_sr   <= tx_data;
                        bit_cnt <= '0;
                    end else if (fall) begin
                        tx_sr <= tx_sr << 1;
                        if (bit_cnt == LAST_BIT) draining <= 1'b1;
                        else                     bit_cnt  <= bit_cnt + BW'(1);
                    end
                    if (period_end && draining) begin
                        draining <= 1'b0;
                        state    <= HOLD;
                    end
                end
                HOLD: if (wait_cnt == DIV_TC) begin
                    wait_cnt <= '0;
                    cs_n     <= 1'b1;
                    state    <= IDLE;
                end else begin
                    wait_cnt <= wait_cnt + CW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SPI_SHIFTER_RX_EN
    logic [WORD_SIZE-1:0] rx_sr, rx_next;

    // With CLK_DIV=1 the last sample and the last fall share a cycle, so publish rx_next
    assign rx_next = rise ? {rx_sr[WORD_SIZE-2:0], miso} : rx_sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sr    <= '0;
            rx_data  <= '0;
            rx_write <= 1'b0;
        end else begin
            rx_write <= word_end;
            if (sclk_en)  rx_sr   <= rx_next;
            if (word_end) rx_data <= rx_next;
        end
    end
`else
    logic unused_rx;
    assign unused_rx = miso ^ rise;
    assign rx_data   = '0;
    assign rx_write  = 1'b0;
`endif
endmodule

// File: tb/tb_spi_master_shifter.sv
// Bench for spi_master_shifter: table of transfers on a CLK_DIV=4 instance, plus
// reset, mid-word abort and a CLK_DIV=1 instance; follows SPI_SHIFTER_RX_EN.
module tb_spi_master_shifter;
`ifdef SPI_SHIFTER_RX_EN
    localparam int RX_ON = 1;
`else
    localparam int RX_ON = 0;
`endif
    localparam logic [17:0] EXP_TR = {1'b0, 16'hAAAA, 1'b0};

    typedef struct {
        logic [7:0] w0;
        logic [7:0] w1;
        int         nw;
        int         mode;    // 0: miso=mosi, 1: miso=0, 2: miso=1
        int         cs_len;
    } vec_t;
    typedef struct {
        logic [7:0] tx;
        logic [7:0] rx;
    } exp_t;

    logic clk = 1'b0, rst;
    logic tx_valid, tx_read, sclk, mosi, cs_n, miso, rx_write, busy;
    logic [7:0] tx_data, rx_data;
    logic tx_valid1, tx_read1, sclk1, mosi1, cs1_n, rx_write1, busy1;
    logic [7:0] tx_data1, rx_data1;

    always #5 clk = ~clk;

    int miso_mode;
    assign miso = (miso_mode == 0) ? mosi : (miso_mode == 2);

    spi_master_shifter #(.WORD_SIZE(8), .CLK_DIV(4)) u_dut (
        .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data), .tx_read(tx_read),
        .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .miso(miso), .rx_data(rx_data),
        .rx_write(rx_write), .busy(busy)
    );
    spi_master_shifter #(.WORD_SIZE(8), .CLK_DIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .tx_valid(tx_valid1), .tx_data(tx_data1), .tx_read(tx_read1),
        .sclk(sclk1), .mosi(mosi1), .cs_n(cs1_n), .miso(1'b0), .rx_data(rx_data1),
        .rx_write(rx_write1), .busy(busy1)
    );

    logic [7:0] src_q[$], src1_q[$];
    exp_t       exp_q[$];
    vec_t       vecs[5];
    vec_t       v81;
    logic       rst_req, rd_pend, rd1_pend, sclk_q;
    logic [7:0] mosi_w, pend_rx;
    logic [17:0] sclk_tr;
    int n_vec, n_err, n_rd, n_wr, n_rd1, n_wr1, nbits;
    int cs_run, last_run, cs1_run, last1_run, rd0, wr0, k;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rx_of(input logic [7:0] w, input int mode);
        if (mode == 0) return w;
        if (mode == 2) return 8'hFF;
        return 8'h00;
    endfunction

    task automatic word_done();
        exp_t e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL mosi_word: got %0h expected no word", mosi_w);
        end else begin
            e = exp_q.pop_front();
            check("mosi_word", {24'h0, mosi_w}, {24'h0, e.tx});
            pend_rx = e.rx;
        end
    endtask

    // One clock: upstream buffer model on the falling edge, outputs sampled 1ns later.
    task automatic tick();
        @(negedge clk);
        rst = rst_req;
        if (rd_pend)  void'(src_q.pop_front());
        if (rd1_pend) void'(src1_q.pop_front());
        tx_valid  = (src_q.size() != 0);
        tx_data   = tx_valid ? src_q[0] : 8'h00;
        tx_valid1 = (src1_q.size() != 0);
        tx_data1  = tx_valid1 ? src1_q[0] : 8'h00;
        #1;
        rd_pend  = tx_read;
        rd1_pend = tx_read1;
        if (tx_read)  n_rd++;
        if (tx_read1) n_rd1++;
        if (sclk && !sclk_q) begin
            mosi_w = {mosi_w[6:0], mosi};
            nbits++;
            if (nbits == 8) begin
                nbits = 0;
                word_done();
            end
        end
        sclk_q = sclk;
        if (rx_write) begin
            n_wr++;
            if (RX_ON != 0) check("rx_data_at_write", {24'h0, rx_data}, {24'h0, pend_rx});
        end
        if (!cs_n) cs_run++;
        else if (cs_run != 0) begin
            last_run = cs_run;
            cs_run   = 0;
        end
        if (!cs1_n) begin
            cs1_run++;
            sclk_tr = {sclk_tr[16:0], sclk1};
        end else if (cs1_run != 0) begin
            last1_run = cs1_run;
            cs1_run   = 0;
        end
        if (rx_write1) n_wr1++;
    endtask

    task automatic load_vec(input vec_t v);
        exp_t e;
        miso_mode = v.mode;
        rd0 = n_rd;
        wr0 = n_wr;
        last_run = 0;
        src_q.push_back(v.w0);
        e.tx = v.w0; e.rx = rx_of(v.w0, v.mode); exp_q.push_back(e);
        if (v.nw == 2) begin
            src_q.push_back(v.w1);
            e.tx = v.w1; e.rx = rx_of(v.w1, v.mode); exp_q.push_back(e);
        end
    endtask

    task automatic finish_vec(input vec_t v);
        int t = 0;
        while (last_run == 0 && t < 3000) begin tick(); t++; end
        if (t >= 3000) begin
            n_vec++;
            n_err++;
            $display("FAIL vec_timeout: got no cs_n release expected one within 3000 cycles");
        end
        repeat (2) tick();
        check("cs_low_len", last_run, v.cs_len);
        check("tx_read_cnt", n_rd - rd0, v.nw);
        check("rx_write_cnt", n_wr - wr0, v.nw * RX_ON);
        check("words_left", exp_q.size(), 0);
        check("rx_data_hold", {24'h0, rx_data}, (RX_ON != 0) ? {24'h0, pend_rx} : 32'h0);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 8'h00, 1, 0, 72};
        vecs[1] = '{8'h3C, 8'hC3, 2, 0, 136};
        vecs[2] = '{8'h5A, 8'h00, 1, 2, 72};
        vecs[3] = '{8'hFF, 8'h00, 1, 1, 72};
        vecs[4] = '{8'h00, 8'hFF, 2, 0, 136};
        v81     = '{8'h81, 8'h00, 1, 0, 72};
        rst = 1'b1; rst_req = 1'b1; miso_mode = 0;
        tx_valid = 1'b0; tx_data = 8'h00; tx_valid1 = 1'b0; tx_data1 = 8'h00;
        rd_pend = 1'b0; rd1_pend = 1'b0; sclk_q = 1'b0; mosi_w = 8'h00; pend_rx = 8'h00;
        sclk_tr = '0;
        n_vec = 0; n_err = 0; n_rd = 0; n_wr = 0; n_rd1 = 0; n_wr1 = 0; nbits = 0;
        cs_run = 0; last_run = 0; cs1_run = 0; last1_run = 0;

        // Reset held with a word already waiting upstream
        load_vec(vecs[0]);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_cs_n", cs_n, 1);
            check("rst_sclk", sclk, 0);
            check("rst_tx_read", tx_read, 0);
        end
        check("rst_busy", busy, 0);
        check("rst_mosi", mosi, 0);
        check("rst_rx_write", rx_write, 0);
        check("rst_rx_data", rx_data, 0);
        rst_req = 1'b0;
        finish_vec(vecs[0]);

        for (int i = 1; i < 5; i++) begin
            load_vec(vecs[i]);
            finish_vec(vecs[i]);
        end

        // Abort a word at its 4th sclk rise
        miso_mode = 0; rd0 = n_rd; wr0 = n_wr;
        src_q.push_back(8'h5A);
        k = 0;
        while (nbits < 4 && k < 500) begin tick(); k++; end
        check("abort_reach_rise4", nbits, 4);
        rst_req = 1'b1;
        tick();
        rst_req = 1'b0;
        tick();
        check("abort_cs_n", cs_n, 1);
        check("abort_sclk", sclk, 0);
        check("abort_busy", busy, 0);
        check("abort_mosi", mosi, 0);
        nbits = 0; mosi_w = 8'h00;
        repeat (20) tick();
        check("abort_rx_write", n_wr - wr0, 0);
        check("abort_tx_read", n_rd - rd0, 1);
        load_vec(v81);
        finish_vec(v81);

        // CLK_DIV=1 instance, all-ones word against miso=0
        src1_q.push_back(8'hFF);
        k = 0;
        while (last1_run == 0 && k < 500) begin tick(); k++; end
        repeat (2) tick();
        check("div1_cs_low_len", last1_run, 18);
        check("div1_sclk_trace", {14'h0, sclk_tr}, {14'h0, EXP_TR});
        check("div1_tx_read_cnt", n_rd1, 1);
        check("div1_rx_write_cnt", n_wr1, RX_ON);
        check("div1_rx_data", rx_data1, 0);
        check("div1_busy", busy1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/spi_master_shifter.md
# spi_master_shifter

SPI mode-0 master serializer sitting directly downstream of the transmit word buffer. Pops one word at a time from the buffer's head via a single-cycle read strobe, shifts it MSB-first onto MOSI with a generated SCLK and chip select, and optionally captures MISO into a parallel word pushed into a receive buffer. Back-to-back words are sent under one continuous chip-select assertion.

## Interface
- WORD_SIZE, 8, bits per SPI word; must be ≥2
- CLK_DIV, 4, SCLK half-period in clk cycles; must be ≥1
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- tx_valid  in  1  upstream buffer holds ≥1 word
- tx_data  in  WORD_SIZE  head word of the upstream buffer, valid whenever tx_valid=1
- tx_read  out  1  one-cycle pop strobe to the upstream buffer; tx_data is captured in the same cycle
- sclk  out  1  SPI clock, idle low
- mosi  out  1  serial data out, MSB first
- cs_n  out  1  chip select, active-low
- miso  in  1  serial data in
- rx_data  out  WORD_SIZE  last received word
- rx_write  out  1  one-cycle push strobe to the receive buffer
- busy  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, SETUP, SHIFT, HOLD.
- IDLE: cs_n=1, sclk=0. If tx_valid=1: assert tx_read, load shift register from tx_data, go to SETUP.
- SETUP: cs_n=0, mosi=shift MSB; lasts CLK_DIV cycles, then SHIFT.
- SHIFT: per bit, sclk high CLK_DIV cycles then low CLK_DIV cycles. Rising edge: sample miso into LSB of rx shift register. Falling edge: shift tx register left, present next bit on mosi. Bit counter 0..WORD_SIZE-1.
- Last falling edge of a word: rx_write pulses with the completed word on rx_data. If tx_valid=1 in that cycle: tx_read pulses, new word loaded, its MSB on mosi, remain in SHIFT with bit counter cleared (no SETUP, cs_n stays low). Otherwise go to HOLD.
- HOLD: cs_n=0, sclk=0 for CLK_DIV cycles, then cs_n=1 and IDLE.
- tx_read never asserts outside IDLE or the last-falling-edge cycle; never asserts when tx_valid=0.
- Divider counter width $clog2(CLK_DIV+1); terminal count CLK_DIV-1, wraps to 0.

## Timing
- Reset values: tx_read=0, sclk=0, mosi=0, cs_n=1, rx_data=0, rx_write=0, busy=0; state IDLE, all counters 0.
- tx_valid sampled in cycle t (IDLE) → tx_read=1 in t; cs_n=0 from t+1.
- Single word: cs_n low for (2·WORD_SIZE+2)·CLK_DIV cycles; first sclk rise at t+1+CLK_DIV.
- rx_write coincides with the last sclk falling edge; rx_data holds value until next rx_write.
- rst asserted mid-word: next edge returns to reset values, word discarded, no rx_write, no tx_read.
- tx_valid dropping mid-word has no effect until the next word boundary.

## Configuration
- SPI_SHIFTER_RX_EN defined: MISO capture, rx_data and rx_write active as above.
- Undefined: rx shift register omitted; rx_data tied 0, rx_write tied 0, miso ignored. Transmit timing identical.

## Structure
- Package spi_pkg: state enum typedef spi_state_t (IDLE, SETUP, SHIFT, HOLD), default WORD_SIZE and CLK_DIV constants.
- Sub-module spi_sclk_gen: divider counter producing one-cycle rise/fall strobes and sclk level while enabled; cleared by rst or disable.

## Test plan
- Reset: hold rst 3 cycles with tx_valid=1 → cs_n=1, sclk=0, tx_read never asserted.
- Single word, WORD_SIZE=8, CLK_DIV=4, tx_data=0xA5, miso looped to mosi → mosi bits 1,0,1,0,0,1,0,1 on rising edges; rx_write once with rx_data=0xA5; cs_n low 72 cycles.
- Back-to-back: two words 0x3C, 0xC3 queued → cs_n low continuously 136 cycles, exactly two tx_read pulses, two rx_write pulses.
- CLK_DIV=1, tx_data=0xFF, miso=0 → sclk toggles every cycle, rx_data=0x00, cs_n low 18 cycles.
- rst asserted at 4th sclk rise → next cycle cs_n=1, sclk=0, no rx_write; later 0x81 transmits cleanly.
- SPI_SHIFTER_RX_EN undefined, tx_data=0x5A, miso=1 → rx_write stays 0, mosi sequence unchanged.
